// File: rtl/lane_judge_pkg.sv
// Shared types and constants for the multi-lane hit judge.
// Grade codes, lane FSM states, score weights and a hit helper.
package lane_judge_pkg;

  typedef enum logic [1:0] {
    GRADE_NONE    = 2'd0,
    GRADE_GOOD    = 2'd1,
    GRADE_PERFECT = 2'd2,
    GRADE_MISS    = 2'd3
  } grade_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DONE
  } lane_state_t;

  localparam int unsigned PTS_PERFECT = 10;
  localparam int unsigned PTS_GOOD    = 5;

  function automatic logic is_hit(grade_t g);
    return (g == GRADE_GOOD) || (g == GRADE_PERFECT);
  endfunction

endpackage

// File: rtl/lane_judge_fsm.sv
// Per-lane judge FSM: IDLE -> ARMED -> DONE, grades one enemy pass.
// Ports: clk, rst (async active-low), pos, pos_valid, key_press in;
// verdict (combinational, same-cycle judgement), hit/miss/grade out
// (registered). Build macro: LANE_JUDGE_EARLY_PENALTY_EN makes an
// out-of-window press in ARMED a MISS instead of being ignored.
module lane_fsm
  import lane_judge_pkg::*;
#(
  parameter int POS_W    = 4,
  parameter int HIT_POS  = 12,
  parameter int GOOD_WIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] pos,
  input  logic             pos_valid,
  input  logic             key_press,
  output grade_t           verdict,
  output logic             hit,
  output logic             miss,
  output logic [1:0]       grade
);

  localparam logic [POS_W:0] HIT  = (POS_W+1)'(HIT_POS);
  localparam logic [POS_W:0] WIN  = (POS_W+1)'(GOOD_WIN);
  localparam logic [POS_W:0] LATE = (POS_W+1)'(HIT_POS + GOOD_WIN);

`ifdef LANE_JUDGE_EARLY_PENALTY_EN
  localparam bit EARLY_PENALTY = 1'b1;
`else
  localparam bit EARLY_PENALTY = 1'b0;
`endif

  lane_state_t      state;
  lane_state_t      state_nx;
  logic             prev_valid;
  logic [POS_W-1:0] prev_pos;
  logic [POS_W:0]   p;
  logic [POS_W:0]   d;

  always_comb begin
    p        = {1'b0, pos};
    d        = (p >= HIT) ? (p - HIT) : (HIT - p);
    verdict  = GRADE_NONE;
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (pos_valid && !prev_valid)
          state_nx = ST_ARMED;
      end
      ST_ARMED: begin
        // press is judged before the pass-line check
        if (key_press && d == '0)
          verdict = GRADE_PERFECT;
        else if (key_press && d <= WIN)
          verdict = GRADE_GOOD;
        else if (key_press && EARLY_PENALTY)
          verdict = GRADE_MISS;
        else if (!pos_valid || p > LATE)
          verdict = GRADE_MISS;
        if (verdict != GRADE_NONE)
          state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (!pos_valid)
          state_nx = ST_IDLE;
        else if (pos < prev_pos)
          state_nx = ST_ARMED;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // prev_valid resets high so a lane already valid at
  // release is not armed until pos_valid rises again
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      prev_valid <= 1'b1;
      prev_pos   <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      grade      <= GRADE_NONE;
    end else begin
      state      <= state_nx;
      prev_valid <= pos_valid;
      prev_pos   <= pos;
      hit        <= is_hit(verdict);
      miss       <= (verdict == GRADE_MISS);
      grade      <= verdict;
    end
  end

endmodule

// File: rtl/lane_judge.sv
// Multi-lane hit judge: one lane_fsm per lane plus combo/score.
// Ports: clk, rst (async active-low), pos, pos_valid, key_press in;
// hit, grade, miss, damage, combo, score out (all registered).
// Build macro: LANE_JUDGE_EARLY_PENALTY_EN (see lane_fsm).
module lane_judge
  import lane_judge_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int POS_W    = 4,
  parameter int HIT_POS  = 12,
  parameter int GOOD_WIN = 2,
  parameter int COMBO_W  = 8,
  parameter int SCORE_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*POS_W-1:0] pos,
  input  logic [LANES-1:0]       pos_valid,
  input  logic [LANES-1:0]       key_press,
  output logic [LANES-1:0]       hit,
  output logic [LANES*2-1:0]     grade,
  output logic [LANES-1:0]       miss,
  output logic                   damage,
  output logic [COMBO_W-1:0]     combo,
  output logic [SCORE_W-1:0]     score
);

  localparam logic [SCORE_W+7:0] SCORE_MAX =
    {8'b0, {SCORE_W{1'b1}}};
  localparam logic [COMBO_W+3:0] COMBO_MAX =
    {4'b0, {COMBO_W{1'b1}}};

  grade_t             verdict [LANES];
  logic [3:0]         n_perf;
  logic [3:0]         n_good;
  logic [3:0]         n_miss;
  logic [3:0]         n_hit;
  logic [SCORE_W+7:0] score_sum;
  logic [SCORE_W-1:0] score_nx;
  logic [COMBO_W+3:0] combo_sum;
  logic [COMBO_W-1:0] combo_nx;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_fsm #(
      .POS_W    (POS_W),
      .HIT_POS  (HIT_POS),
      .GOOD_WIN (GOOD_WIN)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .pos       (pos[i*POS_W +: POS_W]),
      .pos_valid (pos_valid[i]),
      .key_press (key_press[i]),
      .verdict   (verdict[i]),
      .hit       (hit[i]),
      .miss      (miss[i]),
      .grade     (grade[i*2 +: 2])
    );
  end

  // aggregate from same-cycle verdicts so combo/score line
  // up with the registered hit/miss pulses
  always_comb begin
    n_perf = '0;
    n_good = '0;
    n_miss = '0;
    for (int i = 0; i < LANES; i++) begin
      if (verdict[i] == GRADE_PERFECT) n_perf = n_perf + 4'd1;
      if (verdict[i] == GRADE_GOOD)    n_good = n_good + 4'd1;
      if (verdict[i] == GRADE_MISS)    n_miss = n_miss + 4'd1;
    end
    n_hit = n_perf + n_good;
    score_sum = {8'b0, score}
              + (SCORE_W+8)'(n_perf) * (SCORE_W+8)'(PTS_PERFECT)
              + (SCORE_W+8)'(n_good) * (SCORE_W+8)'(PTS_GOOD);
    score_nx = (score_sum > SCORE_MAX) ? '1
             : score_sum[SCORE_W-1:0];
    combo_sum = {4'b0, combo} + (COMBO_W+4)'(n_hit);
    combo_nx = (combo_sum > COMBO_MAX) ? '1
             : combo_sum[COMBO_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      damage <= 1'b0;
      combo  <= '0;
      score  <= '0;
    end else begin
      damage <= (n_miss != '0);
      combo  <= (n_miss != '0) ? '0 : combo_nx;
      score  <= score_nx;
    end
  end

endmodule

// File: tb/tb_lane_judge.sv
// Directed bench for lane_judge with a spec-level reference model.
// Model checked every cycle at negedge, plus literal expectations.
module tb_lane_judge;

  localparam int L = 4;

`ifdef LANE_JUDGE_EARLY_PENALTY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pos = '0;
  logic [3:0]  valid = '0;
  logic [3:0]  press = '0;
  logic [3:0]  hit;
  logic [7:0]  grade;
  logic [3:0]  miss;
  logic        damage;
  logic [7:0]  combo;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lane_judge dut (
    .clk       (clk),
    .rst       (rst),
    .pos       (pos),
    .pos_valid (valid),
    .key_press (press),
    .hit       (hit),
    .grade     (grade),
    .miss      (miss),
    .damage    (damage),
    .combo     (combo),
    .score     (score)
  );

  // ---------------- reference model ----------------
  // phase: 0 waiting for enemy, 1 enemy judgeable, 2 judged
  int          ph [L];
  bit          pv [L];
  int          pp [L];
  logic [3:0]  e_hit;
  logic [3:0]  e_miss;
  logic [7:0]  e_grade;
  logic        e_dmg;
  int          e_combo;
  int          e_score;
  int          mp, md, mg, np, ng, nm;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < L; i++) begin
        ph[i] = 0; pv[i] = 1'b1; pp[i] = 0;
      end
      e_hit = '0; e_miss = '0; e_grade = '0; e_dmg = 1'b0;
      e_combo = 0; e_score = 0;
    end else begin
      np = 0; ng = 0; nm = 0;
      for (int i = 0; i < L; i++) begin
        mp = int'(pos[i*4 +: 4]);
        md = (mp > 12) ? mp - 12 : 12 - mp;
        mg = 0;
        if (ph[i] == 1) begin
          if (press[i] && md == 0) mg = 2;
          else if (press[i] && md <= 2) mg = 1;
          else if (press[i] && EARLY) mg = 3;
          else if (!valid[i] || mp > 14) mg = 3;
          if (mg != 0) ph[i] = 2;
        end else if (ph[i] == 2) begin
          if (!valid[i]) ph[i] = 0;
          else if (mp < pp[i]) ph[i] = 1;
        end else begin
          if (valid[i] && !pv[i]) ph[i] = 1;
        end
        e_grade[i*2 +: 2] = mg[1:0];
        e_hit[i]  = (mg == 1 || mg == 2);
        e_miss[i] = (mg == 3);
        if (mg == 2) np++;
        if (mg == 1) ng++;
        if (mg == 3) nm++;
        pv[i] = valid[i];
        pp[i] = mp;
      end
      e_score = e_score + 10*np + 5*ng;
      if (e_score > 65535) e_score = 65535;
      if (nm > 0) e_combo = 0;
      else e_combo = (e_combo + np + ng > 255) ? 255
                   : e_combo + np + ng;
      e_dmg = (nm > 0);
    end
  end

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_hit",    32'(hit),    32'(e_hit));
    check("m_miss",   32'(miss),   32'(e_miss));
    check("m_grade",  32'(grade),  32'(e_grade));
    check("m_damage", 32'(damage), 32'(e_dmg));
    check("m_combo",  32'(combo),  32'(e_combo));
    check("m_score",  32'(score),  32'(e_score));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic setp(int lane, int v);
    pos[lane*4 +: 4] = 4'(v);
  endtask

  task automatic setall(int v);
    for (int i = 0; i < L; i++) setp(i, v);
  endtask

  initial begin
    tick(); tick();
    check("rst_score", 32'(score), 0);
    check("rst_combo", 32'(combo), 0);
    check("rst_hit",   32'(hit),   0);
    rst = 1'b1;
    tick();

    // lane 0 PERFECT at pos 12
    valid[0] = 1'b1; setp(0, 9); tick();
    setp(0, 10); tick();
    setp(0, 11); tick();
    setp(0, 12); press[0] = 1'b1; tick();
    press = '0;
    check("l0_hit",   32'(hit), 32'h1);
    check("l0_grade", 32'(grade[1:0]), 2);
    check("l0_score", 32'(score), 10);
    check("l0_combo", 32'(combo), 1);
    tick();
    check("l0_pulse", 32'(hit), 0);

    // lane 1 GOOD at pos 10, second press ignored
    valid[1] = 1'b1; setp(1, 8); tick();
    setp(1, 10); press[1] = 1'b1; tick();
    press = '0;
    check("l1_hit",   32'(hit), 32'h2);
    check("l1_grade", 32'(grade[3:2]), 1);
    check("l1_score", 32'(score), 15);
    setp(1, 11); press[1] = 1'b1; tick();
    press = '0;
    check("l1_again", 32'(hit), 0);

    // lane 2: GOOD to reach combo 3, wrap, then pass-line miss
    valid[2] = 1'b1; setp(2, 12); tick();
    setp(2, 13); press[2] = 1'b1; tick();
    press = '0;
    check("l2_combo3", 32'(combo), 3);
    setp(2, 2); tick();
    setp(2, 13); tick();
    setp(2, 14); tick();
    setp(2, 15); tick();
    check("l2_miss",   32'(miss), 32'h4);
    check("l2_dmg",    32'(damage), 1);
    check("l2_grade",  32'(grade[5:4]), 3);
    check("l2_combo0", 32'(combo), 0);
    tick();
    check("l2_dmg_off", 32'(damage), 0);

    // lane 0 PERFECT and lane 3 MISS together
    valid[0] = 1'b0; tick();
    valid[0] = 1'b1; setp(0, 11);
    valid[3] = 1'b1; setp(3, 14); tick();
    setp(0, 12); press[0] = 1'b1; setp(3, 15); tick();
    press = '0;
    check("mix_hit",   32'(hit), 32'h1);
    check("mix_miss",  32'(miss), 32'h8);
    check("mix_dmg",   32'(damage), 1);
    check("mix_score", 32'(score), 30);
    check("mix_combo", 32'(combo), 0);

    // early press on lane 1 at pos 5
    valid[1] = 1'b0; tick();
    valid[1] = 1'b1; setp(1, 5); tick();
    press[1] = 1'b1; tick();
    press = '0;
`ifdef LANE_JUDGE_EARLY_PENALTY_EN
    check("early_miss", 32'(miss), 32'h2);
    check("early_dmg",  32'(damage), 1);
`else
    check("early_none", 32'(miss | hit), 0);
`endif
    setp(1, 12); press[1] = 1'b1; tick();
    press = '0;
`ifdef LANE_JUDGE_EARLY_PENALTY_EN
    check("late_ignored", 32'(hit), 0);
`else
    check("late_perfect", 32'(hit), 32'h2);
    check("late_score",   32'(score), 40);
`endif

    // combo saturation: all lanes wrap and hit PERFECT
    for (int n = 0; n < 70; n++) begin
      setall(0); tick();
      setall(12); press = 4'hF; tick();
      press = '0;
    end
    check("combo_sat", 32'(combo), 255);
    setall(0); tick();
    setall(12); press = 4'hF; tick();
    press = '0;
    check("combo_hold", 32'(combo), 255);
    for (int n = 0; n < 1650; n++) begin
      setall(0); tick();
      setall(12); press = 4'hF; tick();
      press = '0;
    end
    check("score_sat", 32'(score), 65535);

    // reset mid-ARMED discards the pending judgement
    setall(0); tick();
    setall(13); tick();
    rst = 1'b0; press = 4'hF; tick();
    check("rst_hit2",   32'(hit), 0);
    check("rst_score2", 32'(score), 0);
    check("rst_combo2", 32'(combo), 0);
    check("rst_dmg2",   32'(damage), 0);
    rst = 1'b1; press = '0; tick();
    press = 4'hF; tick();
    press = '0;
    check("no_rearm", 32'(hit), 0);
    valid = '0; tick();
    valid = 4'hF; setall(12); tick();
    press = 4'hF; tick();
    press = '0;
    check("rearm_hit",   32'(hit), 32'hF);
    check("rearm_score", 32'(score), 40);
    check("rearm_combo", 32'(combo), 4);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_judge.md
# lane_judge

Multi-lane hit judge for the rhythm-game datapath. Sits between the per-lane enemy position scripts and keyboard decoder on one side, and the player life tracker and the display on the other. It generalises the single-lane judge to `LANES` independent lanes with graded timing windows, miss detection, combo and score. Keys arrive as one-cycle press pulses. It emits per-lane hit pulses, a grade, a single damage pulse, and running combo/score.

## Interface
- `LANES`, 4: number of lanes (1–8).
- `POS_W`, 4: width of each lane position.
- `HIT_POS`, 12: position at which an enemy is exactly on the judgement line.
- `GOOD_WIN`, 2: ± distance from `HIT_POS` still graded GOOD.
- `COMBO_W`, 8: combo counter width.
- `SCORE_W`, 16: score width.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `pos`  in  LANES*POS_W  packed lane positions; lane i at `[i*POS_W +: POS_W]`; counts up as the enemy approaches.
- `pos_valid`  in  LANES  enemy present in lane i.
- `key_press`  in  LANES  one-cycle press pulse for lane i.
- `hit`  out  LANES  one-cycle pulse: lane i graded PERFECT or GOOD.
- `grade`  out  LANES*2  per-lane grade code, valid while that lane's `hit` or `miss` is high.
- `miss`  out  LANES  one-cycle pulse: lane i missed.
- `damage`  out  1  one-cycle pulse when any `miss` bit is high.
- `combo`  out  COMBO_W  current combo count.
- `score`  out  SCORE_W  accumulated score.

## Operation
Each lane runs its own FSM.

- **IDLE**
  - Goes to ARMED when `pos_valid` rises.
  - A key press here is ignored.
- **ARMED**
  - Distance d = |pos − HIT_POS|, computed at POS_W+1 bits, unsigned compare.
  - Press with d==0: grade PERFECT, go to DONE.
  - Press with 0<d≤GOOD_WIN: grade GOOD, go to DONE.
  - Press with d>GOOD_WIN: ignored (see Configuration).
  - If pos > HIT_POS+GOOD_WIN, or `pos_valid` falls, with no qualifying press: grade MISS, go to DONE.
- **DONE**
  - Further presses are ignored.
  - Goes to IDLE when `pos_valid` falls.
  - Goes directly to ARMED when `pos` decreases while valid (a new enemy wrapped in).
- Press and pass-line in the same cycle: the press is evaluated first, so a press at d≤GOOD_WIN scores.
- Grade codes: NONE=0, GOOD=1, PERFECT=2, MISS=3.
- Score and combo update once per cycle, aggregated over all lanes:
  - score += 10·(#PERFECT) + 5·(#GOOD), saturating at all-ones.
  - If any lane has MISS that cycle, combo ← 0. Hits in the same cycle still score but do not add to combo.
  - Otherwise combo += #hits that cycle, saturating at all-ones.
- `damage` is a single pulse regardless of how many lanes miss in the same cycle.

## Timing
- Reset values: all FSMs IDLE; `hit`, `miss`, `grade` = 0; `damage` = 0; `combo` = 0; `score` = 0.
- Reset asserted mid-operation discards any pending judgement with no outputs. After release, lanes that already have `pos_valid` high are not armed until `pos_valid` rises again.
- Latency: an input sampled at edge N produces `hit`/`miss`/`grade`/`damage` high for exactly the cycle following edge N. `combo` and `score` reflect that judgement from the same cycle.
- All outputs are registered. There is no back-pressure and each pulse lasts one cycle.
- `pos` and `pos_valid` must be synchronous to `clk`. The slow script clock is synchronised upstream.

## Configuration
- `LANE_JUDGE_EARLY_PENALTY_EN`
  - Defined: a press in ARMED with d>GOOD_WIN grades MISS, pulses `miss`/`damage`, resets combo and moves the lane to DONE.
  - Undefined: such a press is ignored and the lane stays ARMED.

## Structure
- Package `lane_judge_pkg` holds:
  - grade enum (`GRADE_NONE`, `GRADE_GOOD`, `GRADE_PERFECT`, `GRADE_MISS`);
  - lane state enum (IDLE, ARMED, DONE);
  - score constants `PTS_PERFECT`=10 and `PTS_GOOD`=5.
- Sub-module `lane_fsm` (one instance per lane, in a generate loop) contains:
  - the state register;
  - the previous-pos register;
  - the d computation;
  - the grade output.
- The top level does the cross-lane popcount, combo/score saturation and damage OR.

## Test plan
- Lane 0 valid, pos steps 9→12, press at pos=12 → next cycle `hit[0]`=1, grade PERFECT, score=10, combo=1.
- Lane 1, press at pos=10 (d=2) → GOOD, score +5. A second press at pos=11 → no output (lane in DONE).
- Lane 2, pos steps to 15 with no press → `miss[2]`=1, `damage`=1 for one cycle, combo resets from 3 to 0.
- Same cycle: lane 0 PERFECT and lane 3 MISS → score +10, combo=0, single `damage` pulse.
- Combo at 255 plus one more hit → combo stays 255. Score near 65535 saturates.
- Press at pos=5 with macro defined → MISS and `damage`. Without macro → no output, and a later press at pos=12 → PERFECT. Also: `rst` low mid-ARMED → all outputs 0 and no pending pulse after release.
